// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [31:0] NOP_WORD_DFLT = 32'h0000_0000;

    // True when a byte address is not word aligned or lies beyond the array.
    // The address is zero-extended to 64 bits so one helper serves any PC width.
    function automatic logic fetch_addr_bad(input logic [63:0] addr, input int aw);
        logic [63:0] hi;
        hi = addr >> (aw + 2);
        return (addr[1:0] != 2'b00) || (hi != 64'd0);
    endfunction

endpackage

// File: rtl/instr_mem_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module instr_mem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage deliberately has no reset so a program survives rst.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory for the fetch stage: streaming program
// port, then one-cycle registered fetches with stall and address-error flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset; picks LOAD (prog_en) or RUN on retained image
// LOAD  | prog_ready high, words written at wr_ptr until full or prog_en falls
// RUN   | fetches served; prog_en restarts a load from word 0
module instr_mem_loadable
    import instr_mem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 64,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DFLT)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    prog_en_i,
    input  logic                    prog_valid_i,
    input  logic [DATA_W-1:0]       prog_data_i,
    output logic                    prog_ready_o,
    output logic                    prog_done_o,
    output logic [$clog2(DEPTH):0]  prog_count_o,
    input  logic [ADDR_W-1:0]       pc_i,
    input  logic                    fetch_en_i,
    output logic [DATA_W-1:0]       instruction_o,
    output logic                    instr_valid_o,
    output logic                    addr_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              accept, load_end, fetch, bad, rd_en;
    logic [DATA_W-1:0] rd_data;

    assign bad   = fetch_addr_bad(64'(pc_i), AW);
    assign rd_en = fetch && !bad;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        done_d   = 1'b0;
        valid_d  = valid_q;
        err_d    = err_q;
        accept   = 1'b0;
        load_end = 1'b0;
        fetch    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (prog_en_i) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                    count_d  = '0;
                end else begin
                    state_d = RUN;
                end
            end
            LOAD: begin
                accept = prog_valid_i && ready_q;
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = count_q + CW'(1);
                end
                // A word arriving with the prog_en fall is still written.
                load_end = (accept && (wr_ptr_q == AW'(DEPTH - 1))) || !prog_en_i;
                if (load_end) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end
            end
            RUN: begin
                if (prog_en_i) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                    count_d  = '0;
                end else if (fetch_en_i) begin
                    fetch = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The edge entering RUN samples no fetch, so valid stays low one cycle.
        if (state_d != RUN) begin
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (fetch) begin
            valid_d = 1'b1;
            err_d   = bad;
        end

        ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    instr_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (accept && rst_i),
        .waddr_i (wr_ptr_q),
        .wdata_i (prog_data_i),
        .re_i    (rd_en && rst_i),
        .raddr_i (pc_i[AW+1:2]),
        .rdata_o (rd_data)
    );

    // The read register holds through stalls; errors and non-RUN show NOP.
    assign instruction_o = (valid_q && !err_q) ? rd_data : NOP_WORD;
    assign instr_valid_o = valid_q;
    assign addr_err_o    = err_q;
    assign prog_ready_o  = ready_q;
    assign prog_done_o   = done_q;
    assign prog_count_o  = count_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable: reference memory model plus a
// queue of expected fetch results popped one cycle after each fetch.
module tb_instr_mem_loadable;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_en;
    logic        prog_valid;
    logic [31:0] prog_data;
    logic        prog_ready;
    logic        prog_done;
    logic [6:0]  prog_count;
    logic [31:0] pc;
    logic        fetch_en;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        addr_err;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_mem [64];
    logic [31:0] load_buf  [64];
    exp_t        sb [$];

    always #5 clk = ~clk;

    instr_mem_loadable #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .DEPTH    (64),
        .NOP_WORD (32'h0)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .prog_en_i     (prog_en),
        .prog_valid_i  (prog_valid),
        .prog_data_i   (prog_data),
        .prog_ready_o  (prog_ready),
        .prog_done_o   (prog_done),
        .prog_count_o  (prog_count),
        .pc_i          (pc),
        .fetch_en_i    (fetch_en),
        .instruction_o (instruction),
        .instr_valid_o (instr_valid),
        .addr_err_o    (addr_err)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1);
    end

    // Called at a negedge; returns at the negedge one fetch later.
    task automatic issue_fetch(input logic [31:0] a);
        exp_t e;
        pc       = a;
        fetch_en = 1'b1;
        e.addr   = a;
        e.err    = (a[1:0] != 2'b00) || (a[31:8] != 24'd0);
        e.word   = e.err ? 32'h0 : model_mem[a[7:2]];
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the last accepted word.
    task automatic load_words(input int n);
        int waited;
        waited     = 0;
        prog_en    = 1'b1;
        prog_valid = 1'b0;
        @(negedge clk);
        while (prog_ready !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (prog_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_ready_wait got=%b want=1", prog_ready);
        end
        for (int i = 0; i < n; i++) begin
            prog_valid   = 1'b1;
            prog_data    = load_buf[i];
            model_mem[i] = load_buf[i];
            @(negedge clk);
        end
        prog_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; prog_en = 1'b1; prog_valid = 1'b0; prog_data = '0;
        pc = '0; fetch_en = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (prog_ready !== 1'b0 || prog_done !== 1'b0 || instr_valid !== 1'b0 ||
            addr_err !== 1'b0 || instruction !== 32'h0 || prog_count !== 7'd0) begin
            bad++;
            $display("FAIL reset_state got rdy=%b done=%b v=%b err=%b instr=%h cnt=%0d want 0/0/0/0/0/0",
                     prog_ready, prog_done, instr_valid, addr_err, instruction, prog_count);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (prog_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_to_load got rdy=%b want=1", prog_ready);
        end
        prog_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_load4();
        exp_t e;
        load_buf[0] = 32'h8020000A; load_buf[1] = 32'h04400800;
        load_buf[2] = 32'h0C600800; load_buf[3] = 32'h14821800;
        load_words(4);
        total++;
        if (prog_done !== 1'b0 || prog_ready !== 1'b1) begin
            bad++;
            $display("FAIL load4_pre_done got done=%b rdy=%b want done=0 rdy=1", prog_done, prog_ready);
        end
        prog_en = 1'b0;
        @(negedge clk);
        total++;
        if (prog_done !== 1'b1 || prog_count !== 7'd4 || prog_ready !== 1'b0) begin
            bad++;
            $display("FAIL load4_done got done=%b cnt=%0d rdy=%b want done=1 cnt=4 rdy=0",
                     prog_done, prog_count, prog_ready);
        end
        for (int i = 0; i < 4; i++) begin
            issue_fetch(32'(i * 4));
            e = sb.pop_front();
            total++;
            if (instr_valid !== 1'b1 || instruction !== e.word || addr_err !== e.err ||
                prog_done !== 1'b0 || prog_count !== 7'd4) begin
                bad++;
                $display("FAIL load4_fetch pc=%h got instr=%h v=%b err=%b done=%b cnt=%0d want instr=%h v=1 err=%b done=0 cnt=4",
                         e.addr, instruction, instr_valid, addr_err, prog_done, prog_count, e.word, e.err);
            end
        end
    endtask

    task automatic test_full_load();
        exp_t e;
        logic [31:0] addrs [3];
        for (int i = 0; i < 64; i++) load_buf[i] = $urandom();
        load_words(64);
        total++;
        if (prog_done !== 1'b1 || prog_ready !== 1'b0 || prog_count !== 7'd64) begin
            bad++;
            $display("FAIL full_auto_end got done=%b rdy=%b cnt=%0d want done=1 rdy=0 cnt=64",
                     prog_done, prog_ready, prog_count);
        end
        prog_en = 1'b0;
        addrs[0] = 32'd252; addrs[1] = 32'd0; addrs[2] = 32'd128;
        for (int i = 0; i < 3; i++) begin
            issue_fetch(addrs[i]);
            e = sb.pop_front();
            total++;
            if (instr_valid !== 1'b1 || instruction !== e.word || addr_err !== e.err || prog_done !== 1'b0) begin
                bad++;
                $display("FAIL full_fetch pc=%h got instr=%h v=%b err=%b done=%b want instr=%h v=1 err=%b done=0",
                         e.addr, instruction, instr_valid, addr_err, prog_done, e.word, e.err);
            end
        end
    endtask

    task automatic test_addr_err();
        exp_t e;
        logic [31:0] addrs [7];
        addrs[0] = 32'd2;   addrs[1] = 32'd256; addrs[2] = 32'd8;
        addrs[3] = 32'd1;   addrs[4] = 32'h8000_0000; addrs[5] = 32'd260;
        addrs[6] = 32'd248;
        for (int i = 0; i < 7; i++) begin
            issue_fetch(addrs[i]);
            e = sb.pop_front();
            total++;
            if (instr_valid !== 1'b1 || instruction !== e.word || addr_err !== e.err) begin
                bad++;
                $display("FAIL addr_err_fetch pc=%h got instr=%h v=%b err=%b want instr=%h v=1 err=%b",
                         e.addr, instruction, instr_valid, addr_err, e.word, e.err);
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        issue_fetch(32'd16);
        e = sb.pop_front();
        total++;
        if (instr_valid !== 1'b1 || instruction !== e.word || addr_err !== 1'b0) begin
            bad++;
            $display("FAIL stall_pre pc=%h got instr=%h v=%b err=%b want instr=%h v=1 err=0",
                     e.addr, instruction, instr_valid, addr_err, e.word);
        end
        fetch_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pc = (k == 2) ? 32'd2 : 32'(20 + 4 * k);
            @(negedge clk);
            total++;
            if (instr_valid !== 1'b1 || instruction !== model_mem[4] || addr_err !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got instr=%h v=%b err=%b want instr=%h v=1 err=0",
                         k, instruction, instr_valid, addr_err, model_mem[4]);
            end
        end
        issue_fetch(32'd20);
        e = sb.pop_front();
        total++;
        if (instr_valid !== 1'b1 || instruction !== e.word || addr_err !== 1'b0) begin
            bad++;
            $display("FAIL stall_resume pc=%h got instr=%h v=%b err=%b want instr=%h v=1 err=0",
                     e.addr, instruction, instr_valid, addr_err, e.word);
        end
    endtask

    task automatic test_reset_midload();
        exp_t e;
        for (int i = 0; i < 5; i++) load_buf[i] = 32'hA5A5_0000 + 32'(i);
        load_words(2);
        // A valid word during reset must not be written.
        prog_valid = 1'b1;
        prog_data  = load_buf[2];
        rst        = 1'b0;
        @(negedge clk);
        prog_valid = 1'b0;
        prog_en    = 1'b0;
        @(negedge clk);
        total++;
        if (prog_count !== 7'd0 || prog_done !== 1'b0 || prog_ready !== 1'b0) begin
            bad++;
            $display("FAIL midload_reset got cnt=%0d done=%b rdy=%b want 0/0/0",
                     prog_count, prog_done, prog_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (prog_count !== 7'd0 || prog_done !== 1'b0 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL midload_run_entry got cnt=%0d done=%b v=%b want 0/0/0",
                     prog_count, prog_done, instr_valid);
        end
        for (int i = 0; i < 5; i++) begin
            issue_fetch(32'(i * 4));
            e = sb.pop_front();
            total++;
            if (instr_valid !== 1'b1 || instruction !== e.word || addr_err !== 1'b0 || prog_count !== 7'd0) begin
                bad++;
                $display("FAIL midload_fetch pc=%h got instr=%h v=%b err=%b cnt=%0d want instr=%h v=1 err=0 cnt=0",
                         e.addr, instruction, instr_valid, addr_err, prog_count, e.word);
            end
        end
    endtask

    task automatic test_reprogram();
        exp_t e;
        prog_en = 1'b1;
        @(negedge clk);
        total++;
        if (instr_valid !== 1'b0 || instruction !== 32'h0 || prog_ready !== 1'b1) begin
            bad++;
            $display("FAIL reprog_enter got v=%b instr=%h rdy=%b want v=0 instr=0 rdy=1",
                     instr_valid, instruction, prog_ready);
        end
        // Final word arrives in the same cycle prog_en falls.
        prog_valid   = 1'b1;
        prog_data    = 32'hDEADBEEF;
        model_mem[0] = 32'hDEADBEEF;
        prog_en      = 1'b0;
        @(negedge clk);
        prog_valid = 1'b0;
        total++;
        if (prog_done !== 1'b1 || prog_count !== 7'd1) begin
            bad++;
            $display("FAIL reprog_done got done=%b cnt=%0d want done=1 cnt=1", prog_done, prog_count);
        end
        for (int i = 0; i < 2; i++) begin
            issue_fetch(32'(i * 4));
            e = sb.pop_front();
            total++;
            if (instr_valid !== 1'b1 || instruction !== e.word || addr_err !== 1'b0) begin
                bad++;
                $display("FAIL reprog_fetch pc=%h got instr=%h v=%b err=%b want instr=%h v=1 err=0",
                         e.addr, instruction, instr_valid, addr_err, e.word);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load4();
        test_full_load();
        test_addr_err();
        test_stall();
        test_reset_midload();
        test_reprogram();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
